datapath_sequencer: RTL and testbench

Control sequencer for the single-bus datapath. It steps through fetch and execute for register-to-register ALU, immediate-ALU and load-immediate instructions. It drives every bus-driver enable, register load enable, GRA/GRB/GRC select, BAout and ALU opcode. It sits between the instruction register and the register file / bus multiplexer, and is the only source of those control strobes.

---
 rtl/datapath_seq_pkg.sv | 74 +++++++
 rtl/datapath_sequencer_seq_decode.sv | 29 ++
 rtl/datapath_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_datapath_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_seq_pkg.sv
// Shared definitions for the datapath control sequencer: FSM states,
// opcode values, instruction field positions and the control strobe bundle.
// Optional multiply/divide support is enabled by DATAPATH_SEQ_MULDIV_EN.
package datapath_seq_pkg;

  // Instruction field bit positions within the IR
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;
  localparam int C_MSB   = 18;
  localparam int C_LSB   = 0;

  // Opcodes handled by the sequencer
  localparam logic [4:0] OP_LDI        = 5'b00001;
  localparam logic [4:0] OP_ADD        = 5'b00011;
  localparam logic [4:0] OP_RTYPE_LAST = 5'b01011;
  localparam logic [4:0] OP_ADDI       = 5'b01100;
  localparam logic [4:0] OP_ANDI       = 5'b01101;
  localparam logic [4:0] OP_ORI        = 5'b01110;
  localparam logic [4:0] OP_MUL        = 5'b01111;
  localparam logic [4:0] OP_DIV        = 5'b10000;

  // ALU function codes shared with the ALU (the ALU decodes the opcode itself)
  localparam logic [4:0] ALU_NOP = 5'b00000;
  localparam logic [4:0] ALU_ADD = OP_ADD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5
`ifdef DATAPATH_SEQ_MULDIV_EN
    , ST_T6
`endif
  } state_t;

  // Every single-bit control strobe driven by the sequencer
  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic md_read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic zlo_out;
    logic c_out;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic busy;
    logic done;
    logic illegal;
`ifdef DATAPATH_SEQ_MULDIV_EN
    logic lo_in;
    logic hi_in;
    logic zhi_out;
`endif
  } ctrl_t;

endpackage

// File: rtl/datapath_sequencer_seq_decode.sv
// Opcode classifier for the datapath sequencer. Purely combinational.
// mul/div are recognised only when DATAPATH_SEQ_MULDIV_EN is defined.
module seq_decode
  import datapath_seq_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] i_opcode,
  output logic           o_rtype,
  output logic           o_imm,
  output logic           o_ldi,
  output logic           o_muldiv,
  output logic           o_illegal
);

  // Map the opcode onto one instruction class; anything unmatched is illegal
  always_comb begin
    o_rtype   = (i_opcode >= OP_ADD) && (i_opcode <= OP_RTYPE_LAST);
    o_imm     = (i_opcode == OP_ADDI) || (i_opcode == OP_ANDI) || (i_opcode == OP_ORI);
    o_ldi     = (i_opcode == OP_LDI);
`ifdef DATAPATH_SEQ_MULDIV_EN
    o_muldiv  = (i_opcode == OP_MUL) || (i_opcode == OP_DIV);
`else
    o_muldiv  = 1'b0;
`endif
    o_illegal = !(o_rtype || o_imm || o_ldi || o_muldiv);
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Fetch/execute control sequencer for the single-bus datapath.
// All strobes are registered: each edge loads the outputs of the state being
// entered. Define DATAPATH_SEQ_MULDIV_EN for mul/div (adds T6 and the
// lo_in / hi_in / zhi_out ports).
module datapath_sequencer
  import datapath_seq_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int ALUW = 5
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic            pc_out,
  output logic            mar_in,
  output logic            inc_pc,
  output logic            md_read,
  output logic            mdr_in,
  output logic            mdr_out,
  output logic            ir_in,
  output logic            y_in,
  output logic            z_in,
  output logic            zlo_out,
  output logic            c_out,
  output logic            gra,
  output logic            grb,
  output logic            grc,
  output logic            r_in,
  output logic            r_out,
  output logic            ba_out,
  output logic [ALUW-1:0] alu_op,
  output logic            busy,
  output logic            done,
  output logic            illegal
`ifdef DATAPATH_SEQ_MULDIV_EN
  , output logic          lo_in
  , output logic          hi_in
  , output logic          zhi_out
`endif
);

  state_t          r_state;
  logic [OPW-1:0]  r_opcode;
  ctrl_t           r_ctrl;
  logic [ALUW-1:0] r_alu_op;

  logic [OPW-1:0]  w_op_sel;
  logic            w_rtype;
  logic            w_imm;
  logic            w_ldi;
  logic            w_muldiv;
  logic            w_illegal;
  logic            w_ir_unused;

  // In T2 the opcode is still on the IR and is classified directly so the T3
  // strobes can be registered on the same edge that latches it.
  assign w_op_sel = (r_state == ST_T2) ? ir[OPC_MSB -: OPW] : r_opcode;

  // Register fields are steered by the register file, not by this block
  assign w_ir_unused = ^ir[OPC_MSB-OPW:0];

  seq_decode #(.OPW(OPW)) u_decode (
    .i_opcode  (w_op_sel),
    .o_rtype   (w_rtype),
    .o_imm     (w_imm),
    .o_ldi     (w_ldi),
    .o_muldiv  (w_muldiv),
    .o_illegal (w_illegal)
  );

  // State transitions plus registered Moore outputs for the state being entered
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state  <= ST_IDLE;
      r_opcode <= '0;
      r_ctrl   <= '0;
      r_alu_op <= '0;
    end else begin
      r_ctrl   <= '0;
      r_alu_op <= '0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state       <= ST_T0;
            r_ctrl.busy   <= 1'b1;
            r_ctrl.pc_out <= 1'b1;
            r_ctrl.mar_in <= 1'b1;
            r_ctrl.inc_pc <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_T0: begin
          r_state        <= ST_T1;
          r_ctrl.busy    <= 1'b1;
          r_ctrl.md_read <= 1'b1;
          r_ctrl.mdr_in  <= 1'b1;
        end
        ST_T1: begin
          r_ctrl.busy <= 1'b1;
          if (mem_ready) begin
            r_state        <= ST_T2;
            r_ctrl.mdr_out <= 1'b1;
            r_ctrl.ir_in   <= 1'b1;
          end else begin
            r_state        <= ST_T1;
            r_ctrl.md_read <= 1'b1;
            r_ctrl.mdr_in  <= 1'b1;
          end
        end
        ST_T2: begin
          r_state     <= ST_T3;
          r_opcode    <= ir[OPC_MSB -: OPW];
          r_ctrl.busy <= 1'b1;
          if (w_illegal) begin
            r_ctrl.illegal <= 1'b1;
          end else begin
            r_ctrl.r_out  <= 1'b1;
            r_ctrl.y_in   <= 1'b1;
            r_ctrl.ba_out <= w_ldi;
            if (w_muldiv) r_ctrl.gra <= 1'b1;
            else          r_ctrl.grb <= 1'b1;
          end
        end
        ST_T3: begin
          if (w_illegal) begin
            r_state <= ST_IDLE;
          end else begin
            r_state     <= ST_T4;
            r_ctrl.busy <= 1'b1;
            r_ctrl.z_in <= 1'b1;
            if (w_ldi) begin
              r_ctrl.c_out <= 1'b1;
              r_alu_op     <= ALUW'(ALU_ADD);
            end else if (w_imm) begin
              r_ctrl.c_out <= 1'b1;
              r_alu_op     <= ALUW'(r_opcode);
            end else if (w_muldiv) begin
              r_ctrl.grb   <= 1'b1;
              r_ctrl.r_out <= 1'b1;
              r_alu_op     <= ALUW'(r_opcode);
            end else begin
              r_ctrl.grc   <= 1'b1;
              r_ctrl.r_out <= 1'b1;
              r_alu_op     <= ALUW'(r_opcode);
            end
          end
        end
        ST_T4: begin
          r_state        <= ST_T5;
          r_ctrl.busy    <= 1'b1;
          r_ctrl.zlo_out <= 1'b1;
          if (w_muldiv) begin
`ifdef DATAPATH_SEQ_MULDIV_EN
            r_ctrl.lo_in <= 1'b1;
`endif
          end else begin
            r_ctrl.gra  <= 1'b1;
            r_ctrl.r_in <= 1'b1;
            r_ctrl.done <= 1'b1;
          end
        end
        ST_T5: begin
`ifdef DATAPATH_SEQ_MULDIV_EN
          if (w_muldiv) begin
            r_state        <= ST_T6;
            r_ctrl.busy    <= 1'b1;
            r_ctrl.zhi_out <= 1'b1;
            r_ctrl.hi_in   <= 1'b1;
            r_ctrl.done    <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
`else
          r_state <= ST_IDLE;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pc_out  = r_ctrl.pc_out;
  assign mar_in  = r_ctrl.mar_in;
  assign inc_pc  = r_ctrl.inc_pc;
  assign md_read = r_ctrl.md_read;
  assign mdr_in  = r_ctrl.mdr_in;
  assign mdr_out = r_ctrl.mdr_out;
  assign ir_in   = r_ctrl.ir_in;
  assign y_in    = r_ctrl.y_in;
  assign z_in    = r_ctrl.z_in;
  assign zlo_out = r_ctrl.zlo_out;
  assign c_out   = r_ctrl.c_out;
  assign gra     = r_ctrl.gra;
  assign grb     = r_ctrl.grb;
  assign grc     = r_ctrl.grc;
  assign r_in    = r_ctrl.r_in;
  assign r_out   = r_ctrl.r_out;
  assign ba_out  = r_ctrl.ba_out;
  assign busy    = r_ctrl.busy;
  assign done    = r_ctrl.done;
  assign illegal = r_ctrl.illegal;
  assign alu_op  = r_alu_op;
`ifdef DATAPATH_SEQ_MULDIV_EN
  assign lo_in   = r_ctrl.lo_in;
  assign hi_in   = r_ctrl.hi_in;
  assign zhi_out = r_ctrl.zhi_out;
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer. Each instruction pushes its
// expected per-cycle control pattern onto a queue; every cycle one entry is
// popped and compared against the DUT outputs.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [31:0] ir;
  logic        mem_ready;
  logic        pc_out, mar_in, inc_pc, md_read, mdr_in, mdr_out, ir_in;
  logic        y_in, z_in, zlo_out, c_out;
  logic        gra, grb, grc, r_in, r_out, ba_out;
  logic [4:0]  alu_op;
  logic        busy, done, illegal;
`ifdef DATAPATH_SEQ_MULDIV_EN
  logic        lo_in, hi_in, zhi_out;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [22:0] M_ILL    = 23'h000001;
  localparam logic [22:0] M_DONE   = 23'h000002;
  localparam logic [22:0] M_BUSY   = 23'h000004;
  localparam logic [22:0] M_BA     = 23'h000008;
  localparam logic [22:0] M_ROUT   = 23'h000010;
  localparam logic [22:0] M_RIN    = 23'h000020;
  localparam logic [22:0] M_GRC    = 23'h000040;
  localparam logic [22:0] M_GRB    = 23'h000080;
  localparam logic [22:0] M_GRA    = 23'h000100;
  localparam logic [22:0] M_COUT   = 23'h000200;
  localparam logic [22:0] M_ZLO    = 23'h000400;
  localparam logic [22:0] M_ZIN    = 23'h000800;
  localparam logic [22:0] M_YIN    = 23'h001000;
  localparam logic [22:0] M_IRIN   = 23'h002000;
  localparam logic [22:0] M_MDROUT = 23'h004000;
  localparam logic [22:0] M_MDRIN  = 23'h008000;
  localparam logic [22:0] M_MDRD   = 23'h010000;
  localparam logic [22:0] M_INC    = 23'h020000;
  localparam logic [22:0] M_MAR    = 23'h040000;
  localparam logic [22:0] M_PC     = 23'h080000;
  localparam logic [22:0] M_LOIN   = 23'h100000;
  localparam logic [22:0] M_HIIN   = 23'h200000;
  localparam logic [22:0] M_ZHI    = 23'h400000;

  typedef struct {
    logic [22:0] vec;
    logic [4:0]  alu;
    logic        mr;   // mem_ready to drive during this cycle
  } exp_t;

  exp_t exp_q[$];

  datapath_sequencer #(.OPW(5), .ALUW(5)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .ir        (ir),
    .mem_ready (mem_ready),
    .pc_out    (pc_out),
    .mar_in    (mar_in),
    .inc_pc    (inc_pc),
    .md_read   (md_read),
    .mdr_in    (mdr_in),
    .mdr_out   (mdr_out),
    .ir_in     (ir_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .zlo_out   (zlo_out),
    .c_out     (c_out),
    .gra       (gra),
    .grb       (grb),
    .grc       (grc),
    .r_in      (r_in),
    .r_out     (r_out),
    .ba_out    (ba_out),
    .alu_op    (alu_op),
    .busy      (busy),
    .done      (done),
    .illegal   (illegal)
`ifdef DATAPATH_SEQ_MULDIV_EN
    , .lo_in   (lo_in)
    , .hi_in   (hi_in)
    , .zhi_out (zhi_out)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] get_obs();
    logic [2:0] md;
`ifdef DATAPATH_SEQ_MULDIV_EN
    md = {zhi_out, hi_in, lo_in};
`else
    md = 3'b000;
`endif
    return {md, pc_out, mar_in, inc_pc, md_read, mdr_in, mdr_out, ir_in, y_in, z_in,
            zlo_out, c_out, gra, grb, grc, r_in, r_out, ba_out, busy, done, illegal};
  endfunction

  function automatic logic [5:0] bus_drivers();
    logic zh;
`ifdef DATAPATH_SEQ_MULDIV_EN
    zh = zhi_out;
`else
    zh = 1'b0;
`endif
    return {pc_out, mdr_out, r_out, c_out, zlo_out, zh};
  endfunction

  // 0 illegal, 1 R-type, 2 immediate, 3 ldi, 4 mul/div
  function automatic int classify(input logic [4:0] opc);
    if (opc == 5'b00001) return 3;
    if (opc >= 5'b00011 && opc <= 5'b01011) return 1;
    if (opc >= 5'b01100 && opc <= 5'b01110) return 2;
`ifdef DATAPATH_SEQ_MULDIV_EN
    if (opc == 5'b01111 || opc == 5'b10000) return 4;
`endif
    return 0;
  endfunction

  task automatic push_e(input logic [22:0] v, input logic [4:0] a, input logic m);
    exp_t e;
    e.vec = v;
    e.alu = a;
    e.mr  = m;
    exp_q.push_back(e);
  endtask

  // Present an instruction on ir and queue its full expected cycle pattern,
  // ending with the IDLE cycle that follows.
  task automatic push_instr(input logic [31:0] instr, input int stalls);
    logic [4:0] opc;
    int cls;
    opc = instr[31:27];
    cls = classify(opc);
    ir  = instr;
    push_e(M_PC | M_MAR | M_INC | M_BUSY, 5'd0, 1'b1);
    for (int i = 0; i <= stalls; i++)
      push_e(M_MDRD | M_MDRIN | M_BUSY, 5'd0, (i == stalls));
    push_e(M_MDROUT | M_IRIN | M_BUSY, 5'd0, 1'b1);
    case (cls)
      0: push_e(M_ILL | M_BUSY, 5'd0, 1'b1);
      1: begin
        push_e(M_GRB | M_ROUT | M_YIN | M_BUSY, 5'd0, 1'b1);
        push_e(M_GRC | M_ROUT | M_ZIN | M_BUSY, opc, 1'b1);
        push_e(M_ZLO | M_GRA | M_RIN | M_DONE | M_BUSY, 5'd0, 1'b1);
      end
      2: begin
        push_e(M_GRB | M_ROUT | M_YIN | M_BUSY, 5'd0, 1'b1);
        push_e(M_COUT | M_ZIN | M_BUSY, opc, 1'b1);
        push_e(M_ZLO | M_GRA | M_RIN | M_DONE | M_BUSY, 5'd0, 1'b1);
      end
      3: begin
        push_e(M_GRB | M_ROUT | M_BA | M_YIN | M_BUSY, 5'd0, 1'b1);
        push_e(M_COUT | M_ZIN | M_BUSY, 5'b00011, 1'b1);
        push_e(M_ZLO | M_GRA | M_RIN | M_DONE | M_BUSY, 5'd0, 1'b1);
      end
      default: begin
        push_e(M_GRA | M_ROUT | M_YIN | M_BUSY, 5'd0, 1'b1);
        push_e(M_GRB | M_ROUT | M_ZIN | M_BUSY, opc, 1'b1);
        push_e(M_ZLO | M_LOIN | M_BUSY, 5'd0, 1'b1);
        push_e(M_ZHI | M_HIIN | M_DONE | M_BUSY, 5'd0, 1'b1);
      end
    endcase
    push_e(23'd0, 5'd0, 1'b1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One observed cycle: pop the expected entry (IDLE if none) and compare
  task automatic check_cycle(input string name);
    exp_t e;
    logic [22:0] obs;
    logic [5:0]  drv;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin
      e.vec = '0;
      e.alu = '0;
      e.mr  = 1'b1;
    end
    obs = get_obs();
    drv = bus_drivers();
    checks++;
    if (obs !== e.vec) begin
      errors++;
      $display("FAIL %s ctrl: actual=%06h required=%06h", name, obs, e.vec);
    end
    checks++;
    if (alu_op !== e.alu) begin
      errors++;
      $display("FAIL %s alu_op: actual=%05b required=%05b", name, alu_op, e.alu);
    end
    checks++;
    if ($countones(drv) > 1) begin
      errors++;
      $display("FAIL %s bus_onehot: actual drivers=%06b required at most one", name, drv);
    end
    checks++;
    if ($countones({gra, grb, grc}) > 1) begin
      errors++;
      $display("FAIL %s gr_excl: actual gra/grb/grc=%b%b%b required at most one", name, gra, grb, grc);
    end
    checks++;
    if (ba_out && !(grb && r_out)) begin
      errors++;
      $display("FAIL %s ba_out: actual grb=%b r_out=%b required both with ba_out", name, grb, r_out);
    end
    mem_ready = e.mr;
  endtask

  task automatic run_cycles(input int n, input logic hold, input string name);
    for (int c = 0; c < n; c++) begin
      step();
      if (!hold) start = 1'b0;
      check_cycle(name);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (get_obs() !== 23'd0 || alu_op !== 5'd0) begin
      errors++;
      $display("FAIL reset_init: actual=%06h/%05b required=000000/00000", get_obs(), alu_op);
    end
    step();
    step();
    clr = 1'b1;
    run_cycles(2, 1'b0, "reset_idle");
    $display("test_reset: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_add();
    start = 1'b1;
    push_instr(32'h19888000, 0);
    run_cycles(4, 1'b0, "add");
    ir = 32'hF8000000;   // opcode already latched; must not disturb T4/T5
    run_cycles(4, 1'b0, "add");
    $display("test_add: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_ldi();
    start = 1'b1;
    push_instr(32'h0A80001F, 0);
    run_cycles(8, 1'b0, "ldi");
    start = 1'b1;
    push_instr({5'b01101, 4'd1, 4'd2, 19'h00F0F}, 0);
    run_cycles(8, 1'b0, "andi");
    $display("test_ldi: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_stall();
    start = 1'b1;
    push_instr(32'h19888000, 3);
    run_cycles(11, 1'b0, "stall");
    $display("test_stall: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_illegal();
    start = 1'b1;
    push_instr(32'hF8000000, 0);
    run_cycles(6, 1'b0, "illegal");
`ifndef DATAPATH_SEQ_MULDIV_EN
    start = 1'b1;
    push_instr({5'b01111, 4'd2, 4'd4, 19'd0}, 0);
    run_cycles(6, 1'b0, "mul_disabled");
`endif
    $display("test_illegal: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    push_instr(32'h19888000, 0);
    run_cycles(5, 1'b0, "rst_mid");   // last observed cycle is T4
    #1;
    clr = 1'b0;
    #1;
    checks++;
    if (get_obs() !== 23'd0 || alu_op !== 5'd0) begin
      errors++;
      $display("FAIL rst_async: actual=%06h/%05b required=000000/00000", get_obs(), alu_op);
    end
    exp_q.delete();
    mem_ready = 1'b1;
    step();
    clr = 1'b1;
    run_cycles(3, 1'b0, "rst_after");
    $display("test_reset_mid: checks=%0d errors=%0d", checks, errors);
  endtask

`ifdef DATAPATH_SEQ_MULDIV_EN
  task automatic test_muldiv();
    start = 1'b1;
    push_instr({5'b01111, 4'd2, 4'd4, 19'd0}, 0);
    run_cycles(9, 1'b0, "mul");
    $display("test_muldiv: checks=%0d errors=%0d", checks, errors);
  endtask
`endif

  // start stays high; each instruction is queued as the previous one drains
  task automatic test_back_to_back();
    logic [31:0] instr;
    start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      instr = $urandom();
      push_instr(instr, int'($urandom_range(0, 2)));
      start = 1'b1;
      run_cycles(exp_q.size(), 1'b1, "stream");
      $display("stream instr %0d ir=%08h checks=%0d errors=%0d", k, instr, checks, errors);
    end
    start = 1'b0;
    run_cycles(2, 1'b0, "stream_end");
  endtask

  initial begin
    clr       = 1'b0;
    start     = 1'b0;
    ir        = 32'd0;
    mem_ready = 1'b1;
    test_reset();
    test_add();
    test_ldi();
    test_stall();
    test_illegal();
    test_reset_mid();
`ifdef DATAPATH_SEQ_MULDIV_EN
    test_muldiv();
`endif
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
